// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with payload, control and a delayed late-control lane. Optional PIPE_STAT_EN adds stall/flush counters.
// Latency: data/ctrl/valid are 1 edge after capture; the late lane is 1+LATE_DEPTH non-stalled edges after capture.
// Backpressure: stall_in holds the whole stage; flush_in loads a bubble and overrides stall.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 8,
    parameter int LATE_W     = 7,
    parameter int LATE_DEPTH = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [LATE_W-1:0] late_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [LATE_W-1:0] late_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    generate
        if (LATE_DEPTH < 0 || LATE_DEPTH > 4) begin : g_bad_depth
            $fatal(1, "pipe_stage_reg: LATE_DEPTH=%0d outside 0..4", LATE_DEPTH);
        end
    endgenerate

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [LATE_W-1:0] late_q [0:LATE_DEPTH];

    // Main stage register; data is not cleared by a bubble on load, only by flush.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (flush_in) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (!stall_in) begin
            valid_q <= valid_in;
            data_q  <= data_in;
            ctrl_q  <= valid_in ? ctrl_in : '0;
        end
    end

    // Late chain: a flush kills only the head, entries in flight keep moving.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            for (int i = 0; i <= LATE_DEPTH; i++) begin
                late_q[i] <= '0;
            end
        end else if (flush_in || !stall_in) begin
            late_q[0] <= (!flush_in && valid_in) ? late_in : '0;
            for (int i = 1; i <= LATE_DEPTH; i++) begin
                late_q[i] <= late_q[i-1];
            end
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign ctrl_out  = ctrl_q;
    assign late_out  = late_q[LATE_DEPTH];

`ifdef PIPE_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters; a flush edge is never also counted as a stall.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (flush_in) begin
            if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end else if (stall_in) begin
            if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with LATE_DEPTH=2, CNT_W=3; counter expectations follow PIPE_STAT_EN.
module tb_pipe_stage_reg;

    logic        clock = 1'b0;
    logic        nreset;
    logic        stall_in;
    logic        flush_in;
    logic        valid_in;
    logic [31:0] data_in;
    logic [7:0]  ctrl_in;
    logic [6:0]  late_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [7:0]  ctrl_out;
    logic [6:0]  late_out;
    logic [2:0]  stall_cnt;
    logic [2:0]  flush_cnt;

    int total  = 0;
    int passed = 0;

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(8), .LATE_W(7), .LATE_DEPTH(2), .CNT_W(3)
    ) dut (
        .clock(clock), .nreset(nreset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in), .late_in(late_in),
        .valid_out(valid_out), .data_out(data_out), .ctrl_out(ctrl_out), .late_out(late_out),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] cexp(input int v);
`ifdef PIPE_STAT_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c, input logic [6:0] l);
        valid_in = v;
        data_in  = d;
        ctrl_in  = c;
        late_in  = l;
    endtask

    task automatic chk_stage(input string tag, input logic v, input logic [31:0] d,
                             input logic [7:0] c, input logic [6:0] l);
        chk({tag, ".valid"}, 32'(valid_out), 32'(v));
        chk({tag, ".data"},  data_out, d);
        chk({tag, ".ctrl"},  32'(ctrl_out), 32'(c));
        chk({tag, ".late"},  32'(late_out), 32'(l));
    endtask

    initial begin
        // Reset with junk on every input
        nreset = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 8'hFF, 7'h7F);
        tick(); tick();
        chk_stage("reset", 1'b0, 32'h0, 8'h00, 7'h00);
        chk("reset.stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset.flush_cnt", 32'(flush_cnt), 32'h0);

        // Load
        nreset = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 8'hA5, 7'h5A);
        tick();
        chk_stage("load", 1'b1, 32'hDEAD_BEEF, 8'hA5, 7'h00);

        // Bubble gates ctrl and late head, not data
        drive(1'b0, 32'h0000_1234, 8'hFF, 7'h11);
        tick();
        chk_stage("bubble", 1'b0, 32'h0000_1234, 8'h00, 7'h00);

        // 0x5A captured two edges ago arrives now
        drive(1'b1, 32'h0000_0011, 8'h3C, 7'h22);
        tick();
        chk_stage("load11", 1'b1, 32'h0000_0011, 8'h3C, 7'h5A);

        // Three stall edges hold everything
        stall_in = 1'b1;
        drive(1'b1, 32'h0000_0022, 8'h0F, 7'h33);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_stage("stall", 1'b1, 32'h0000_0011, 8'h3C, 7'h5A);
        end
        chk("stall.stall_cnt", 32'(stall_cnt), cexp(3));

        // Release: 0x22 appears one edge later; head captures 0x33
        stall_in = 1'b0;
        tick();
        chk_stage("release", 1'b1, 32'h0000_0022, 8'h0F, 7'h00);

        // One stall edge inside the late-lane flight of 0x33
        stall_in = 1'b1;
        drive(1'b1, 32'h0000_0077, 8'h77, 7'h77);
        tick();
        chk_stage("stall2", 1'b1, 32'h0000_0022, 8'h0F, 7'h00);
        chk("stall2.stall_cnt", 32'(stall_cnt), cexp(4));

        stall_in = 1'b0;
        drive(1'b1, 32'h0000_0055, 8'h81, 7'h01);
        tick();
        chk_stage("resume", 1'b1, 32'h0000_0055, 8'h81, 7'h22);

        // Flush wins over stall; in-flight late entries keep moving
        flush_in = 1'b1; stall_in = 1'b1;
        tick();
        chk_stage("flush_stall", 1'b0, 32'h0, 8'h00, 7'h33);
        chk("flush_stall.stall_cnt", 32'(stall_cnt), cexp(4));
        chk("flush_stall.flush_cnt", 32'(flush_cnt), cexp(1));

        stall_in = 1'b0;
        tick();
        chk_stage("flush", 1'b0, 32'h0, 8'h00, 7'h01);
        chk("flush.flush_cnt", 32'(flush_cnt), cexp(2));

        // Heads killed by the flushes never surface
        flush_in = 1'b0;
        drive(1'b1, 32'h0000_00AB, 8'h12, 7'h7F);
        tick();
        chk_stage("post_flush", 1'b1, 32'h0000_00AB, 8'h12, 7'h00);

        // Six more stall edges: ten in total, counter saturates at 7
        stall_in = 1'b1;
        drive(1'b0, 32'h0, 8'h00, 7'h00);
        for (int i = 0; i < 6; i++) tick();
        chk_stage("long_stall", 1'b1, 32'h0000_00AB, 8'h12, 7'h00);
        chk("sat.stall_cnt", 32'(stall_cnt), cexp(7));
        chk("sat.flush_cnt", 32'(flush_cnt), cexp(2));

        // Reset mid-stall clears stage, whole late chain and counters
        nreset = 1'b0;
        tick();
        chk_stage("reset_mid", 1'b0, 32'h0, 8'h00, 7'h00);
        chk("reset_mid.stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset_mid.flush_cnt", 32'(flush_cnt), 32'h0);

        nreset = 1'b1; stall_in = 1'b0;
        tick();
        chk("drain1.late", 32'(late_out), 32'h0);
        tick();
        chk("drain2.late", 32'(late_out), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
